bulk_in_scheduler: RTL and testbench

- Single-clock controller in the USB clock domain that shares the device's transmit path between NUM_EP bulk IN endpoint FIFOs.
- On each decoded IN token it either:
  - selects the addressed endpoint, raises its xfer strobe, sends a DATA0/DATA1 PID and streams up to MAX_PKT bytes to the packet encoder; or
  - answers NAK when that endpoint has no data.
- Tracks one data toggle per endpoint and advances it only on host ACK.

---
 rtl/bulk_in_scheduler.sv | 142 ++++++++++++++
 tb/tb_bulk_in_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bulk_in_scheduler.sv
// Bulk IN scheduler: shares the transmit path between
// several bulk IN endpoint FIFOs and tracks data toggles.
module bulk_in_scheduler #(
  parameter int NUM_EP  = 2,
  parameter int EP_BASE = 1,
  parameter int MAX_PKT = 512
) (
  input  logic                  usb_clock,
  input  logic                  reset,
  input  logic                  token_valid_i,
  input  logic [3:0]            token_ep_i,
  input  logic                  hsk_ack_i,
  input  logic                  hsk_timeout_i,
  input  logic [NUM_EP-1:0]     toggle_clear_i,
  input  logic [NUM_EP-1:0]     ep_has_data_i,
  output logic [NUM_EP-1:0]     ep_xfer_o,
  input  logic [NUM_EP-1:0]     ep_tvalid_i,
  output logic [NUM_EP-1:0]     ep_tready_o,
  input  logic [NUM_EP-1:0]     ep_tlast_i,
  input  logic [8*NUM_EP-1:0]   ep_tdata_i,
  output logic                  tx_start_o,
  output logic [3:0]            tx_pid_o,
  output logic                  tx_tvalid_o,
  input  logic                  tx_tready_i,
  output logic                  tx_tlast_o,
  output logic [7:0]            tx_tdata_o,
  output logic                  xfer_err_o,
  output logic                  busy_o
);

  localparam int SW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int CW = $clog2(MAX_PKT) + 1;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_NAK   = 4'hA;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA     = 2'd1,
    WAIT_HSK = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [SW-1:0]     sel;
  logic [CW-1:0]     count;
  logic [NUM_EP-1:0] toggle;
  logic [NUM_EP-1:0] flip;
  logic [3:0]        tok_off;
  logic [SW-1:0]     tok_idx;
  logic              tok_hit;
  logic              tok_data;
  logic              beat;
  logic              last_beat;

  assign tok_off  = token_ep_i - 4'(EP_BASE);
  assign tok_idx  = tok_off[SW-1:0];
  assign tok_hit  = token_valid_i
                  && ({1'b0, token_ep_i} >= 5'(EP_BASE))
                  && ({1'b0, tok_off} < 5'(NUM_EP));
  assign tok_data = ep_has_data_i[tok_idx];
  assign beat      = tx_tvalid_o & tx_tready_i;
  assign last_beat = beat & tx_tlast_o;
  assign busy_o    = (state != IDLE);

  // State register
  always_ff @(posedge usb_clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decision
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (tok_hit && tok_data) state_n = DATA;
      DATA:
        if (last_beat) state_n = WAIT_HSK;
      WAIT_HSK:
        if (hsk_ack_i || hsk_timeout_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stream mux from the selected endpoint to the encoder
  always_comb begin
    tx_tvalid_o = 1'b0;
    tx_tdata_o  = 8'h00;
    tx_tlast_o  = 1'b0;
    ep_tready_o = '0;
    if (state == DATA) begin
      tx_tvalid_o      = ep_tvalid_i[sel];
      tx_tdata_o       = ep_tdata_i[{sel, 3'b000} +: 8];
      ep_tready_o[sel] = tx_tready_i;
      tx_tlast_o       = tx_tvalid_o
                       & (ep_tlast_i[sel]
                       | (count == CW'(MAX_PKT - 1)));
    end
  end

  // Toggle flips on ACK of the selected endpoint
  always_comb begin
    flip = '0;
    if (state == WAIT_HSK && hsk_ack_i) flip[sel] = 1'b1;
  end

  // Selection, counters, toggles and response strobes
  always_ff @(posedge usb_clock) begin
    if (reset) begin
      sel        <= '0;
      count      <= '0;
      toggle     <= '0;
      ep_xfer_o  <= '0;
      tx_start_o <= 1'b0;
      tx_pid_o   <= 4'h0;
      xfer_err_o <= 1'b0;
    end else begin
      tx_start_o <= 1'b0;
      xfer_err_o <= 1'b0;
      toggle     <= (toggle ^ flip) & ~toggle_clear_i;
      if (state == IDLE && tok_hit) begin
        sel        <= tok_idx;
        tx_start_o <= 1'b1;
        if (tok_data) begin
          tx_pid_o  <= toggle[tok_idx] ? PID_DATA1
                                       : PID_DATA0;
          ep_xfer_o <= NUM_EP'(1) << tok_idx;
          count     <= '0;
        end else begin
          tx_pid_o  <= PID_NAK;
        end
      end
      if (state == DATA && beat) count <= count + 1'b1;
      if (state == DATA && last_beat) ep_xfer_o <= '0;
      if (state == WAIT_HSK && !hsk_ack_i && hsk_timeout_i)
        xfer_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bulk_in_scheduler.sv
// Self-checking bench for bulk_in_scheduler with a
// transaction-level model of toggles and packet splitting.
module tb_bulk_in_scheduler;

  localparam int NUM_EP  = 2;
  localparam int EP_BASE = 1;
  localparam int MAX_PKT = 8;

  logic                usb_clock = 1'b0;
  logic                reset = 1'b1;
  logic                token_valid_i = 1'b0;
  logic [3:0]          token_ep_i = '0;
  logic                hsk_ack_i = 1'b0;
  logic                hsk_timeout_i = 1'b0;
  logic [NUM_EP-1:0]   toggle_clear_i = '0;
  logic [NUM_EP-1:0]   ep_has_data_i = '0;
  logic [NUM_EP-1:0]   ep_xfer_o;
  logic [NUM_EP-1:0]   ep_tvalid_i = '0;
  logic [NUM_EP-1:0]   ep_tready_o;
  logic [NUM_EP-1:0]   ep_tlast_i = '0;
  logic [8*NUM_EP-1:0] ep_tdata_i = '0;
  logic                tx_start_o;
  logic [3:0]          tx_pid_o;
  logic                tx_tvalid_o;
  logic                tx_tready_i = 1'b0;
  logic                tx_tlast_o;
  logic [7:0]          tx_tdata_o;
  logic                xfer_err_o;
  logic                busy_o;

  int total = 0;
  int bad = 0;

  bit       tog [NUM_EP];
  bit [8:0] sq[$];

  bulk_in_scheduler #(
    .NUM_EP(NUM_EP), .EP_BASE(EP_BASE), .MAX_PKT(MAX_PKT)
  ) dut (
    .usb_clock(usb_clock), .reset(reset),
    .token_valid_i(token_valid_i), .token_ep_i(token_ep_i),
    .hsk_ack_i(hsk_ack_i), .hsk_timeout_i(hsk_timeout_i),
    .toggle_clear_i(toggle_clear_i),
    .ep_has_data_i(ep_has_data_i), .ep_xfer_o(ep_xfer_o),
    .ep_tvalid_i(ep_tvalid_i), .ep_tready_o(ep_tready_o),
    .ep_tlast_i(ep_tlast_i), .ep_tdata_i(ep_tdata_i),
    .tx_start_o(tx_start_o), .tx_pid_o(tx_pid_o),
    .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i),
    .tx_tlast_o(tx_tlast_o), .tx_tdata_o(tx_tdata_o),
    .xfer_err_o(xfer_err_o), .busy_o(busy_o)
  );

  always #5 usb_clock = ~usb_clock;

  task automatic step();
    @(posedge usb_clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++)
      sq.push_back({(i == n - 1) ? 1'b1 : 1'b0,
                    8'($urandom)});
  endtask

  task automatic token(input int ep,
                       input logic [1:0] has,
                       output bit started);
    bit in_rng;
    int idx;
    in_rng = (ep >= EP_BASE) && (ep < EP_BASE + NUM_EP);
    idx = in_rng ? ep - EP_BASE : 0;
    started = in_rng && has[idx];
    token_valid_i = 1'b1;
    token_ep_i = 4'(ep);
    ep_has_data_i = has;
    step();
    token_valid_i = 1'b0;
    chk("tx_start", 32'(tx_start_o), 32'(in_rng));
    if (in_rng)
      chk("tx_pid", 32'(tx_pid_o),
          !started ? 32'hA : (tog[idx] ? 32'hB : 32'h3));
    chk("busy_tok", 32'(busy_o), 32'(started));
    chk("xfer_tok", 32'(ep_xfer_o),
        started ? 32'(1 << idx) : 32'h0);
  endtask

  task automatic stream(input int idx, input bit inject);
    int  cnt;
    bit  done;
    bit  v, r, lf, xl;
    cnt = 0;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      v = (sq.size() > 0) && ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 3) != 0;
      lf = (sq.size() > 0) ? sq[0][8] : 1'b0;
      ep_tvalid_i = NUM_EP'($urandom);
      ep_tvalid_i[idx] = v;
      ep_tlast_i = NUM_EP'($urandom);
      ep_tlast_i[idx] = lf;
      ep_tdata_i = 16'($urandom);
      if (sq.size() > 0) ep_tdata_i[8*idx +: 8] = sq[0][7:0];
      tx_tready_i = r;
      token_valid_i = inject && ($urandom_range(0, 2) == 0);
      token_ep_i = 4'($urandom);
      ep_has_data_i = NUM_EP'($urandom);
      #1;
      xl = v && (lf || cnt == MAX_PKT - 1);
      chk("tvalid", 32'(tx_tvalid_o), 32'(v));
      if (v) chk("tdata", 32'(tx_tdata_o), 32'(sq[0][7:0]));
      chk("tlast", 32'(tx_tlast_o), 32'(xl));
      chk("tready", 32'(ep_tready_o),
          r ? 32'(1 << idx) : 32'h0);
      step();
      chk("no_start", 32'(tx_start_o), 32'h0);
      if (v && r) begin
        void'(sq.pop_front());
        cnt++;
        if (xl) done = 1;
        else chk("xfer_mid", 32'(ep_xfer_o),
                 32'(1 << idx));
      end
    end
    token_valid_i = 1'b0;
    ep_tvalid_i = '0;
    tx_tready_i = 1'b0;
    chk("pkt_done", 32'(done), 32'h1);
    chk("xfer_end", 32'(ep_xfer_o), 32'h0);
    chk("busy_wait", 32'(busy_o), 32'h1);
  endtask

  task automatic hsk(input bit ack, input bit to,
                     input logic [1:0] clr, input int idx);
    hsk_ack_i = ack;
    hsk_timeout_i = to;
    toggle_clear_i = clr;
    step();
    hsk_ack_i = 1'b0;
    hsk_timeout_i = 1'b0;
    toggle_clear_i = '0;
    if (ack) tog[idx] = !tog[idx];
    for (int i = 0; i < NUM_EP; i++)
      if (clr[i]) tog[i] = 0;
    chk("xfer_err", 32'(xfer_err_o), 32'(!ack && to));
    chk("busy_hsk", 32'(busy_o), 32'h0);
    step();
    chk("err_pulse", 32'(xfer_err_o), 32'h0);
  endtask

  task automatic txn(input int idx, input int n,
                     input bit ack, input bit to,
                     input logic [1:0] clr);
    bit st;
    if (n > 0) load(n);
    token(idx + EP_BASE, 2'(1 << idx), st);
    if (st) begin
      stream(idx, 1'b0);
      hsk(ack, to, clr, idx);
    end
  endtask

  initial begin
    bit st;
    int ep, idx, h;
    logic [1:0] has;
    step();
    step();
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_start", 32'(tx_start_o), 32'h0);
    chk("rst_pid", 32'(tx_pid_o), 32'h0);
    chk("rst_xfer", 32'(ep_xfer_o), 32'h0);
    chk("rst_err", 32'(xfer_err_o), 32'h0);
    chk("rst_tvalid", 32'(tx_tvalid_o), 32'h0);
    chk("rst_tlast", 32'(tx_tlast_o), 32'h0);
    chk("rst_tready", 32'(ep_tready_o), 32'h0);
    reset = 1'b0;
    step();

    txn(0, 4, 1, 0, 2'b00);
    txn(0, 1, 1, 0, 2'b00);

    token(2, 2'b00, st);
    step();
    chk("nak_busy", 32'(busy_o), 32'h0);
    chk("nak_xfer", 32'(ep_xfer_o), 32'h0);

    txn(0, 12, 1, 0, 2'b00);
    txn(0, 0, 1, 0, 2'b00);

    txn(1, 2, 0, 1, 2'b00);
    txn(1, 2, 1, 1, 2'b00);

    load(5);
    token(1, 2'b01, st);
    stream(0, 1'b1);
    hsk(1, 0, 2'b00, 0);
    token(7, 2'b11, st);
    step();
    chk("ign7_start", 32'(tx_start_o), 32'h0);
    token(3, 2'b11, st);

    txn(1, 1, 1, 0, 2'b00);
    txn(1, 1, 1, 0, 2'b10);
    txn(1, 1, 1, 0, 2'b00);

    load(6);
    token(1, 2'b01, st);
    ep_tvalid_i = 2'b11;
    tx_tready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ep_tdata_i[7:0] = sq[0][7:0];
      ep_tlast_i = '0;
      step();
      void'(sq.pop_front());
    end
    reset = 1'b1;
    step();
    chk("mrst_xfer", 32'(ep_xfer_o), 32'h0);
    chk("mrst_tvalid", 32'(tx_tvalid_o), 32'h0);
    chk("mrst_busy", 32'(busy_o), 32'h0);
    reset = 1'b0;
    ep_tvalid_i = '0;
    tx_tready_i = 1'b0;
    sq.delete();
    for (int i = 0; i < NUM_EP; i++) tog[i] = 0;
    txn(0, 1, 1, 0, 2'b00);
    txn(1, 1, 1, 0, 2'b00);

    ep = 1;
    for (int it = 0; it < 40; it++) begin
      if (sq.size() == 0) begin
        ep = $urandom_range(0, 8);
        has = 2'($urandom);
        idx = ep - EP_BASE;
        if (idx >= 0 && idx < NUM_EP && has[idx])
          load($urandom_range(1, 12));
      end else begin
        has = 2'($urandom);
        has[ep - EP_BASE] = 1'b1;
      end
      token(ep, has, st);
      if (st) begin
        idx = ep - EP_BASE;
        stream(idx, 1'b1);
        h = $urandom_range(0, 2);
        hsk(h != 1, h != 0,
            ($urandom_range(0, 3) == 0) ? 2'($urandom)
                                        : 2'b00, idx);
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
